// File: rtl/seq_stage_ctrl_if.sv
// Handshake and status bundle between the SEQ stage sequencer and its datapath.
// With SEQ_PERF_CNT_EN defined the bundle also carries the cycle and instruction counters.
interface seq_stage_ctrl_if;
  logic        start_i;
  logic [3:0]  icode_i;
  logic        imem_valid_i;
  logic        imem_err_i;
  logic        cnd_i;
  logic        dmem_ready_i;
  logic        dmem_err_i;
  logic        fetch_en_o;
  logic        decode_en_o;
  logic        execute_en_o;
  logic        dmem_req_o;
  logic        rf_we_o;
  logic        rf_wsel_o;
  logic        pc_en_o;
  logic        busy_o;
  logic [1:0]  stat_o;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_cnt_o;
  logic [31:0] instr_cnt_o;

  modport master (
    input  start_i, icode_i, imem_valid_i, imem_err_i, cnd_i, dmem_ready_i, dmem_err_i,
    output fetch_en_o, decode_en_o, execute_en_o, dmem_req_o, rf_we_o, rf_wsel_o,
           pc_en_o, busy_o, stat_o, cyc_cnt_o, instr_cnt_o
  );
  modport slave (
    output start_i, icode_i, imem_valid_i, imem_err_i, cnd_i, dmem_ready_i, dmem_err_i,
    input  fetch_en_o, decode_en_o, execute_en_o, dmem_req_o, rf_we_o, rf_wsel_o,
           pc_en_o, busy_o, stat_o, cyc_cnt_o, instr_cnt_o
  );
`else
  modport master (
    input  start_i, icode_i, imem_valid_i, imem_err_i, cnd_i, dmem_ready_i, dmem_err_i,
    output fetch_en_o, decode_en_o, execute_en_o, dmem_req_o, rf_we_o, rf_wsel_o,
           pc_en_o, busy_o, stat_o
  );
  modport slave (
    output start_i, icode_i, imem_valid_i, imem_err_i, cnd_i, dmem_ready_i, dmem_err_i,
    input  fetch_en_o, decode_en_o, execute_en_o, dmem_req_o, rf_we_o, rf_wsel_o,
           pc_en_o, busy_o, stat_o
  );
`endif
endinterface

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath with Moore-decoded stage enables.
// Optional SEQ_PERF_CNT_EN adds busy-cycle and retired-instruction counters.
module seq_stage_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  seq_stage_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXECUTE = 4'd3,
    S_MEMORY  = 4'd4,
    S_WB_E    = 4'd5,
    S_WB_M    = 4'd6,
    S_PC_UPD  = 4'd7,
    S_HALT    = 4'd8,
    S_ERR     = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_ADR = 2'b10,
    STAT_INS = 2'b11
  } stat_t;

  localparam int NUM_STATES = 10;

  // Instruction class tables, one bit per icode.
  localparam logic [15:0] MEM_MASK    = 16'h0F30;  // mrmovq rmmovq call ret pushq popq
  localparam logic [15:0] NEED_E_MASK = 16'h0F48;  // irmovq OPq and the rsp updaters
  localparam logic [15:0] NEED_M_MASK = 16'h0820;  // mrmovq popq

  state_t          state_reg, state_next;
  stat_t           stat_reg, stat_next;
  logic [3:0]      icode_reg, icode_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;

  logic [NUM_STATES-1:0] state_hot;
  logic                  is_mem;
  logic                  need_e;
  logic                  need_m;
  logic                  cmov_taken;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STATES; gi++) begin : g_state_hot
      assign state_hot[gi] = (state_reg == state_t'(gi));
    end
  endgenerate

  assign is_mem     = MEM_MASK[icode_reg];
  assign need_m     = NEED_M_MASK[icode_reg];
  // cmovXX only writes when the condition evaluated during EXECUTE holds.
  assign cmov_taken = (icode_reg == 4'h2) && bus.cnd_i;
  assign need_e     = NEED_E_MASK[icode_reg];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg  <= S_IDLE;
      stat_reg   <= STAT_AOK;
      icode_reg  <= 4'h1;
      to_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      stat_reg   <= stat_next;
      icode_reg  <= icode_next;
      to_cnt_reg <= to_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    stat_next   = stat_reg;
    icode_next  = icode_reg;
    to_cnt_next = to_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start_i) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_err_i) begin
          state_next = S_ERR;
          stat_next  = STAT_ADR;
        end else if (bus.imem_valid_i) begin
          if (bus.icode_i == 4'h0) begin
            state_next = S_HALT;
            stat_next  = STAT_HLT;
          end else if (bus.icode_i > 4'hB) begin
            state_next = S_ERR;
            stat_next  = STAT_INS;
          end else begin
            icode_next = bus.icode_i;
            state_next = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_mem) begin
          state_next  = S_MEMORY;
          to_cnt_next = '0;
        end else if (need_e || cmov_taken) begin
          state_next = S_WB_E;
        end else begin
          state_next = S_PC_UPD;
        end
      end
      S_MEMORY: begin
        if (bus.dmem_err_i) begin
          state_next = S_ERR;
          stat_next  = STAT_ADR;
        end else if (bus.dmem_ready_i) begin
          if (need_e)      state_next = S_WB_E;
          else if (need_m) state_next = S_WB_M;
          else             state_next = S_PC_UPD;
        end else if (to_cnt_reg == TO_W'(MEM_TIMEOUT - 1)) begin
          state_next = S_ERR;
          stat_next  = STAT_ADR;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      S_WB_E: begin
        // popq writes rsp first, then the popped value into rA.
        state_next = need_m ? S_WB_M : S_PC_UPD;
      end
      S_WB_M: begin
        state_next = S_PC_UPD;
      end
      S_PC_UPD: begin
        state_next = S_FETCH;
      end
      S_HALT, S_ERR: begin
        state_next = state_reg;
      end
      default: begin
        state_next = S_ERR;
        stat_next  = STAT_INS;
      end
    endcase
  end

  assign bus.fetch_en_o   = state_hot[S_FETCH];
  assign bus.decode_en_o  = state_hot[S_DECODE];
  assign bus.execute_en_o = state_hot[S_EXECUTE];
  assign bus.dmem_req_o   = state_hot[S_MEMORY];
  assign bus.rf_we_o      = state_hot[S_WB_E] | state_hot[S_WB_M];
  assign bus.rf_wsel_o    = state_hot[S_WB_M];
  assign bus.pc_en_o      = state_hot[S_PC_UPD];
  assign bus.busy_o       = ~(state_hot[S_IDLE] | state_hot[S_HALT] | state_hot[S_ERR]);
  assign bus.stat_o       = stat_reg;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_cnt_reg;
  logic [31:0] instr_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_cnt_reg   <= '0;
      instr_cnt_reg <= '0;
    end else begin
      if (bus.busy_o)  cyc_cnt_reg   <= cyc_cnt_reg + 32'd1;
      if (bus.pc_en_o) instr_cnt_reg <= instr_cnt_reg + 32'd1;
    end
  end

  assign bus.cyc_cnt_o   = cyc_cnt_reg;
  assign bus.instr_cnt_o = instr_cnt_reg;
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Reactive bench for seq_stage_ctrl: plays instruction/data memory and checks
// per-instruction timing and write-back pattern against an instruction-level model.
module tb_seq_stage_ctrl;
  localparam int MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  seq_stage_ctrl_if bus();

  seq_stage_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(5)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction-level model: stage count and write-back pattern from the ISA classes.
  function automatic bit m_mem(input logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction
  function automatic bit m_ne(input logic [3:0] ic, input logic c);
    return (ic inside {4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) || (ic == 4'h2 && c);
  endfunction
  function automatic bit m_nm(input logic [3:0] ic);
    return ic inside {4'h5, 4'hB};
  endfunction
  function automatic int m_cycles(input logic [3:0] ic, input logic c, input int w);
    return 3 + (m_mem(ic) ? w + 1 : 0) + int'(m_ne(ic, c)) + int'(m_nm(ic)) + 1;
  endfunction

  task automatic clear_inputs();
    bus.start_i      = 1'b0;
    bus.icode_i      = 4'h1;
    bus.imem_valid_i = 1'b0;
    bus.imem_err_i   = 1'b0;
    bus.cnd_i        = 1'b0;
    bus.dmem_ready_i = 1'b0;
    bus.dmem_err_i   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_cpu();
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge after PC_UPD,
  // at the first non-busy negedge, or (stop_wbm) at the negedge inside WB_M.
  task automatic run_instr(input logic [3:0] ic, input logic c, input int w,
                           input bit derr, input bit ierr, input bit stop_wbm,
                           output int cyc, output int we_n, output int hist,
                           output int req_n, output bit done);
    bit fin;
    cyc = 0; we_n = 0; hist = 0; req_n = 0; done = 0; fin = 0;
    for (int k = 0; k < 64 && !fin; k++) begin
      bus.imem_valid_i = bus.fetch_en_o & ~ierr;
      bus.imem_err_i   = bus.fetch_en_o & ierr;
      bus.icode_i      = ic;
      bus.cnd_i        = c;
      bus.dmem_ready_i = bus.dmem_req_o && (req_n == w);
      bus.dmem_err_i   = bus.dmem_req_o && derr && (req_n == w);
      if (bus.busy_o) cyc++;
      if (bus.rf_we_o) begin
        we_n++;
        hist = hist * 2 + int'(bus.rf_wsel_o);
      end
      if (bus.dmem_req_o) req_n++;
      if (bus.pc_en_o) begin
        done = 1;
        fin  = 1;
        @(negedge clk);
      end else if (!bus.busy_o) begin
        fin = 1;
      end else if (stop_wbm && bus.rf_we_o && bus.rf_wsel_o) begin
        fin = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!fin) chk("cycle_budget", 32'd0, 32'd1);
    $display("[TB] instr icode=%0h cnd=%0d wait=%0d cycles=%0d we=%0d req=%0d stat=%0d",
             ic, c, w, cyc, we_n, req_n, bus.stat_o);
  endtask

  task automatic run_and_check(input string tag, input logic [3:0] ic, input logic c, input int w);
    int cyc, we_n, hist, req_n;
    bit done;
    run_instr(ic, c, w, 1'b0, 1'b0, 1'b0, cyc, we_n, hist, req_n, done);
    chk({tag, "_cycles"}, cyc, m_cycles(ic, c, w));
    chk({tag, "_we"},     we_n, int'(m_ne(ic, c)) + int'(m_nm(ic)));
    chk({tag, "_wsel"},   hist, int'(m_nm(ic)));
    chk({tag, "_req"},    req_n, m_mem(ic) ? w + 1 : 0);
    chk({tag, "_done"},   32'(done), 32'd1);
    chk({tag, "_stat"},   32'(bus.stat_o), 32'd0);
  endtask

  initial begin
    int cyc, we_n, hist, req_n;
    bit done;
    logic [3:0] ric;
    logic rc;
    int rw;

    clear_inputs();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_fetch_en", 32'(bus.fetch_en_o), 32'd0);
    chk("rst_dmem_req", 32'(bus.dmem_req_o), 32'd0);
    chk("rst_rf_we",    32'(bus.rf_we_o),    32'd0);
    chk("rst_pc_en",    32'(bus.pc_en_o),    32'd0);
    chk("rst_busy",     32'(bus.busy_o),     32'd0);
    chk("rst_stat",     32'(bus.stat_o),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold_busy", 32'(bus.busy_o), 32'd0);

    start_cpu();
    chk("start_fetch_en", 32'(bus.fetch_en_o), 32'd1);
    run_and_check("opq", 4'h6, 1'b0, 0);
    run_and_check("popq_w3", 4'hB, 1'b0, 3);
    run_and_check("cmov_c0", 4'h2, 1'b0, 0);
    run_and_check("cmov_c1", 4'h2, 1'b1, 0);
    run_and_check("nop", 4'h1, 1'b0, 0);
    run_and_check("mrmovq", 4'h5, 1'b0, 0);
    run_and_check("rmmovq", 4'h4, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      ric = 4'($urandom_range(1, 11));
      rc  = 1'($urandom_range(0, 1));
      rw  = int'($urandom_range(0, 4));
      run_and_check("rand", ric, rc, rw);
    end

    // Reset during the second write of popq.
    run_instr(4'hB, 1'b0, 0, 1'b0, 1'b0, 1'b1, cyc, we_n, hist, req_n, done);
    chk("wbm_reached", we_n, 2);
    chk("wbm_wsel", 32'(bus.rf_wsel_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_wbm_we",   32'(bus.rf_we_o),   32'd0);
    chk("rst_wbm_busy", 32'(bus.busy_o),    32'd0);
    chk("rst_wbm_pc",   32'(bus.pc_en_o),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_wbm_idle", 32'(bus.busy_o | bus.pc_en_o | bus.rf_we_o), 32'd0);

    start_cpu();
    run_instr(4'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, cyc, we_n, hist, req_n, done);
    chk("halt_stat", 32'(bus.stat_o), 32'd1);
    chk("halt_busy", 32'(bus.busy_o), 32'd0);
    chk("halt_cycles", cyc, 1);
    start_cpu();
    repeat (3) @(negedge clk);
    chk("halt_sticky_stat",  32'(bus.stat_o),     32'd1);
    chk("halt_sticky_fetch", 32'(bus.fetch_en_o), 32'd0);
    chk("halt_sticky_busy",  32'(bus.busy_o),     32'd0);

    do_reset();
    chk("rst_after_halt_stat", 32'(bus.stat_o), 32'd0);
    start_cpu();
    run_instr(4'hC, 1'b0, 0, 1'b0, 1'b0, 1'b0, cyc, we_n, hist, req_n, done);
    chk("ins_stat", 32'(bus.stat_o), 32'd3);
    start_cpu();
    repeat (2) @(negedge clk);
    chk("ins_sticky_stat", 32'(bus.stat_o), 32'd3);
    chk("ins_sticky_busy", 32'(bus.busy_o), 32'd0);

    do_reset();
    start_cpu();
    run_instr(4'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0, cyc, we_n, hist, req_n, done);
    chk("imem_err_stat", 32'(bus.stat_o), 32'd2);

    do_reset();
    start_cpu();
    run_instr(4'h5, 1'b0, 1000, 1'b0, 1'b0, 1'b0, cyc, we_n, hist, req_n, done);
    chk("timeout_req",    req_n, MEM_TIMEOUT);
    chk("timeout_stat",   32'(bus.stat_o), 32'd2);
    chk("timeout_cycles", cyc, 3 + MEM_TIMEOUT);
    chk("timeout_we",     we_n, 0);

    do_reset();
    start_cpu();
    run_instr(4'h4, 1'b0, 1, 1'b1, 1'b0, 1'b0, cyc, we_n, hist, req_n, done);
    chk("derr_stat", 32'(bus.stat_o), 32'd2);
    chk("derr_req",  req_n, 2);
    chk("derr_pc",   32'(done), 32'd0);

`ifdef SEQ_PERF_CNT_EN
    do_reset();
    chk("perf_rst_cyc",   bus.cyc_cnt_o,   32'd0);
    chk("perf_rst_instr", bus.instr_cnt_o, 32'd0);
    start_cpu();
    for (int i = 0; i < 3; i++) begin
      run_instr(4'h1, 1'b0, 0, 1'b0, 1'b0, 1'b0, cyc, we_n, hist, req_n, done);
    end
    chk("perf_cyc",   bus.cyc_cnt_o,   32'd12);
    chk("perf_instr", bus.instr_cnt_o, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
